// File: rtl/fir_stim_capture.sv
// Stimulus source and response capture for the FIR pin interface.
// Drives one DEPTH-sample pattern per run, records the FIR response into a
// DEPTH-entry buffer, then lets a host pop the captured words one per cycle.
module fir_stim_capture #(
    parameter int unsigned BW_in  = 6,
    parameter int unsigned BW_out = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [BW_in-1:0]  amp,
    output logic [BW_in-1:0]  x_out,
    input  logic [BW_out-1:0] y_in,
    output logic              busy,
    output logic              done,
    input  logic              rd_en,
    output logic [BW_out-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_empty
);

    localparam int unsigned KW  = $clog2(DEPTH);
    localparam int unsigned PW  = KW + 1;
    localparam int unsigned FCW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [KW-1:0] K_LAST    = KW'(DEPTH - 1);
    localparam logic [PW-1:0] P_FULL    = PW'(DEPTH);
    localparam logic [7:0]    LFSR_SEED = 8'h01;

    localparam logic [1:0] M_IMPULSE = 2'd0;
    localparam logic [1:0] M_STEP    = 2'd1;
    localparam logic [1:0] M_LFSR    = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [KW-1:0]       r_k, w_k_nxt;
    logic [FCW-1:0]      r_fc, w_fc_nxt;
    logic [7:0]          r_lfsr, w_lfsr_nxt;
    logic [1:0]          r_mode, w_mode_nxt;
    logic [BW_in-1:0]    r_amp, w_amp_nxt;
    logic [PW-1:0]       r_wp, w_wp_nxt;
    logic [PW-1:0]       r_rp, w_rp_nxt;
    logic [BW_in-1:0]    w_x_nxt;
    logic                w_we;
    logic                w_pop;
    logic [BW_out-1:0]   r_buf [DEPTH];

    // Maximal-length 8-bit Fibonacci LFSR advance.
    function automatic logic [7:0] f_lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Pattern sample k for the selected mode.
    function automatic logic [BW_in-1:0] f_sample(
        input logic [1:0]       m,
        input logic [BW_in-1:0] a,
        input logic [KW-1:0]    k,
        input logic [7:0]       l
    );
        logic [BW_in-1:0] v;
        v = BW_in'(k);
        case (m)
            M_IMPULSE: v = (k == '0) ? a : '0;
            M_STEP:    v = a;
            M_LFSR:    v = BW_in'(l);
            default:   v = BW_in'(k);
        endcase
        return v;
    endfunction

    // Next-state, pattern generation, capture and pop decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_fc_nxt    = r_fc;
        w_lfsr_nxt  = r_lfsr;
        w_mode_nxt  = r_mode;
        w_amp_nxt   = r_amp;
        w_wp_nxt    = r_wp;
        w_rp_nxt    = r_rp;
        w_x_nxt     = '0;
        w_we        = 1'b0;
        w_pop       = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // start has priority over a same-cycle pop
                    w_state_nxt = S_DRIVE;
                    w_mode_nxt  = mode;
                    w_amp_nxt   = amp;
                    w_k_nxt     = '0;
                    w_wp_nxt    = '0;
                    w_rp_nxt    = '0;
                    w_x_nxt     = f_sample(mode, amp, '0, LFSR_SEED);
                    w_lfsr_nxt  = f_lfsr_step(LFSR_SEED);
                end else if (r_state == S_DONE && rd_en && r_rp != P_FULL) begin
                    w_pop    = 1'b1;
                    w_rp_nxt = r_rp + PW'(1);
                end
            end
            S_DRIVE: begin
                // the response to sample 0 appears LAT cycles into the run
                w_we = (32'(r_k) >= LAT);
                if (r_k == K_LAST) begin
                    w_state_nxt = S_FLUSH;
                    w_fc_nxt    = '0;
                end else begin
                    w_k_nxt    = r_k + KW'(1);
                    w_x_nxt    = f_sample(r_mode, r_amp, r_k + KW'(1), r_lfsr);
                    w_lfsr_nxt = f_lfsr_step(r_lfsr);
                end
            end
            S_FLUSH: begin
                w_we = 1'b1;
                if (32'(r_fc) == LAT - 1) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_fc_nxt = r_fc + FCW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // never write past the last entry
        if (r_wp == P_FULL) begin
            w_we = 1'b0;
        end
        if (w_we) begin
            w_wp_nxt = r_wp + PW'(1);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_fc     <= '0;
            r_lfsr   <= LFSR_SEED;
            r_mode   <= '0;
            r_amp    <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            x_out    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_empty <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_k      <= w_k_nxt;
            r_fc     <= w_fc_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_mode   <= w_mode_nxt;
            r_amp    <= w_amp_nxt;
            r_wp     <= w_wp_nxt;
            r_rp     <= w_rp_nxt;
            x_out    <= w_x_nxt;
            busy     <= (w_state_nxt == S_DRIVE) || (w_state_nxt == S_FLUSH);
            done     <= (w_state_nxt == S_DONE);
            rd_valid <= w_pop;
            rd_empty <= (w_state_nxt != S_DONE) || (w_rp_nxt == P_FULL);
            if (w_pop) begin
                rd_data <= r_buf[r_rp[KW-1:0]];
            end
        end
    end

    // Capture buffer; contents are don't-care until written by a run.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_buf[r_wp[KW-1:0]] <= y_in;
        end
    end

endmodule

// File: tb/tb_fir_stim_capture.sv
// Self-checking bench for fir_stim_capture with an ideal LAT=1 loopback FIR.
module tb_fir_stim_capture;

    localparam int BW_IN  = 6;
    localparam int BW_OUT = 8;
    localparam int DEPTH  = 16;
    localparam int LAT    = 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [1:0]        mode;
    logic [BW_IN-1:0]  amp;
    logic [BW_IN-1:0]  x_out;
    logic [BW_OUT-1:0] y_in;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [BW_OUT-1:0] rd_data;
    logic              rd_valid;
    logic              rd_empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [BW_IN-1:0]  exp_x [DEPTH];
    logic [BW_OUT-1:0] exp_y [DEPTH];
    logic [BW_IN-1:0]  obs_x [DEPTH];

    fir_stim_capture #(
        .BW_in  (BW_IN),
        .BW_out (BW_OUT),
        .DEPTH  (DEPTH),
        .LAT    (LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .amp      (amp),
        .x_out    (x_out),
        .y_in     (y_in),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_empty (rd_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal FIR: one-cycle delay with sign extension.
    always @(posedge clk) y_in <= BW_OUT'($signed(x_out));

    // Watchdog so a stuck design still terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Expected stimulus and captured words from the pattern definitions.
    function automatic void build_model(input int m, input int a);
        int l;
        int v;
        int s;
        int fb;
        l = 1;
        for (int k = 0; k < DEPTH; k++) begin
            case (m)
                0:       v = (k == 0) ? a : 0;
                1:       v = a;
                2: begin
                    v  = l;
                    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
                    l  = ((l << 1) & 255) | fb;
                end
                default: v = k;
            endcase
            s = v & ((1 << BW_IN) - 1);
            exp_x[k] = BW_IN'(s);
            if (s >= (1 << (BW_IN - 1))) s = s - (1 << BW_IN);
            exp_y[k] = BW_OUT'(s);
        end
    endfunction

    // Launch a run and follow it to DONE, checking every driven sample.
    task automatic run_capture(input int m, input int a, input int inject_at, input bit with_pop);
        int cycles;
        build_model(m, a);
        @(posedge clk); #1;
        start = 1'b1; mode = 2'(m); amp = BW_IN'(a); rd_en = with_pop;
        @(posedge clk); #1;
        start = 1'b0; rd_en = 1'b0;
        if (with_pop) begin
            n_checks++;
            if (rd_valid !== 1'b0) begin
                n_fail++; $display("FAIL start_vs_pop rd_valid: got %b want 0", rd_valid);
            end
        end
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            n_checks++;
            if (cycles < DEPTH) begin
                obs_x[cycles] = x_out;
                if (x_out !== exp_x[cycles]) begin
                    n_fail++; $display("FAIL x_out[%0d] mode %0d: got %0d want %0d", cycles, m, x_out, exp_x[cycles]);
                end
            end else if (x_out !== '0) begin
                n_fail++; $display("FAIL x_out flush: got %0d want 0", x_out);
            end
            if (cycles == inject_at) begin
                start = 1'b1; mode = 2'(m ^ 1); amp = BW_IN'(a + 7);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        n_checks++;
        if (cycles != DEPTH + LAT) begin
            n_fail++; $display("FAIL busy_cycles: got %0d want %0d", cycles, DEPTH + LAT);
        end
        n_checks++;
        if (done !== 1'b1 || rd_empty !== 1'b0 || x_out !== '0) begin
            n_fail++; $display("FAIL done_state: done %b rd_empty %b x_out %0d want 1 0 0", done, rd_empty, x_out);
        end
    endtask

    // Pop n words back to back, comparing against expected entries base...
    task automatic read_words(input int n, input int base);
        @(posedge clk); #1;
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == n - 1) rd_en = 1'b0;
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_y[base + i]) begin
                n_fail++; $display("FAIL read[%0d]: valid %b data %h want 1 %h", base + i, rd_valid, rd_data, exp_y[base + i]);
            end
        end
        n_checks++;
        if (rd_empty !== ((base + n == DEPTH) ? 1'b1 : 1'b0)) begin
            n_fail++; $display("FAIL rd_empty after %0d pops: got %b", base + n, rd_empty);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (x_out !== '0 || busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 ||
            rd_data !== '0 || rd_empty !== 1'b1) begin
            n_fail++; $display("FAIL reset_state: x %0d busy %b done %b vld %b data %h empty %b",
                               x_out, busy, done, rd_valid, rd_data, rd_empty);
        end
        @(posedge clk); #1;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || rd_empty !== 1'b1) begin
            n_fail++; $display("FAIL idle_pop: vld %b empty %b want 0 1", rd_valid, rd_empty);
        end
    endtask

    task automatic test_impulse();
        run_capture(0, 5, -1, 1'b0);
        read_words(DEPTH, 0);
        n_checks++;
        if (exp_y[0] !== 8'h05) begin
            n_fail++; $display("FAIL impulse_model: got %h want 05", exp_y[0]);
        end
    endtask

    task automatic test_step_and_empty_pop();
        run_capture(1, -3, -1, 1'b0);
        read_words(DEPTH, 0);
        @(posedge clk); #1;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || rd_empty !== 1'b1) begin
            n_fail++; $display("FAIL empty_pop: vld %b empty %b want 0 1", rd_valid, rd_empty);
        end
    endtask

    task automatic test_ramp();
        run_capture(3, 0, -1, 1'b0);
        read_words(DEPTH, 0);
    endtask

    task automatic test_lfsr();
        int first5 [5];
        first5 = '{1, 2, 4, 8, 17};
        run_capture(2, 0, -1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (int'(obs_x[i]) != first5[i]) begin
                n_fail++; $display("FAIL lfsr_seq[%0d]: got %0d want %0d", i, obs_x[i], first5[i]);
            end
        end
        read_words(DEPTH, 0);
    endtask

    task automatic test_start_ignored();
        run_capture(3, 0, 4, 1'b0);
        read_words(DEPTH, 0);
    endtask

    task automatic test_start_with_pop();
        run_capture(0, 9, -1, 1'b0);
        read_words(3, 0);
        run_capture(1, -7, -1, 1'b1);
        read_words(DEPTH, 0);
    endtask

    task automatic test_async_reset();
        build_model(3, 0);
        @(posedge clk); #1;
        start = 1'b1; mode = 2'd3; amp = '0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (x_out !== '0 || busy !== 1'b0 || rd_empty !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: x %0d busy %b empty %b done %b", x_out, busy, rd_empty, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: busy %b done %b want 0 0", busy, done);
        end
    endtask

    task automatic test_random();
        int m;
        int a;
        for (int r = 0; r < 4; r++) begin
            m = int'($urandom_range(0, 3));
            a = int'($urandom_range(0, 63)) - 32;
            run_capture(m, a, -1, 1'b0);
            read_words(DEPTH, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = '0; amp = '0; rd_en = 1'b0;
        #22;
        rst_n = 1'b1;
        test_reset();
        test_impulse();
        test_step_and_empty_pop();
        test_ramp();
        test_lfsr();
        test_start_ignored();
        test_start_with_pop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_stim_capture.md
Name: fir_stim_capture

Overview:
On-chip stimulus source and response capture for the FIR datapath. Drives signed BW_in-bit samples onto the FIR input pins. Records the FIR's BW_out-bit output stream into a DEPTH-entry buffer, which a host then reads out through a valid/enable handshake. Sits on the opposite side of the FIR's io_in/io_out pin interface and enables self-test without external pattern hardware.

Parameters:
BW_in, 6, FIR input sample width (signed).
BW_out, 8, FIR output sample width (signed).
DEPTH, 16, samples driven per run and buffer entries captured; power of 2, 2..64.
LAT, 1, FIR input-to-output latency in clocks; must be >= 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle run request; honoured only in IDLE or DONE.
mode  in  2  pattern: 0 impulse, 1 step, 2 LFSR, 3 ramp; sampled on accepted start.
amp  in  BW_in  signed amplitude for impulse/step; sampled on accepted start.
x_out  out  BW_in  sample to FIR input.
y_in  in  BW_out  FIR output.
busy  out  1  high in DRIVE and FLUSH.
done  out  1  high in DONE.
rd_en  in  1  pop request.
rd_data  out  BW_out  popped sample.
rd_valid  out  1  rd_data valid this cycle.
rd_empty  out  1  no unread entries.

Behaviour:
- Reset (async assert, sync release): state IDLE; x_out=0, busy=0, done=0, rd_valid=0, rd_data=0, rd_empty=1; all counters and pointers 0; LFSR=8'h01. Reset during a run aborts it; buffer contents are discarded.
- States: IDLE -> DRIVE on start. DRIVE -> FLUSH after DEPTH cycles. FLUSH -> DONE after LAT cycles. DONE -> DRIVE on start. There is no other transition. start is ignored while busy.
- Accepted start: latch mode and amp, clear the write pointer, the read pointer and the sample index k, and reload the LFSR to 8'h01. x_out presents sample 0 in the first DRIVE cycle.
- DRIVE, sample k = 0..DEPTH-1, x_out registered:
  - impulse: amp when k=0, else 0.
  - step: amp.
  - ramp: k[BW_in-1:0], wrapping.
  - LFSR: lfsr[BW_in-1:0], then lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- FLUSH and all other non-DRIVE states: x_out=0.
- Capture: y_in is written to buf[wp] and wp increments on each cycle from DRIVE cycle LAT through the last FLUSH cycle. This is exactly DEPTH writes. buf[j] is the FIR response to sample j.
- DONE: busy=0, done=1. rd_empty = (rp == DEPTH).
- Readout: rd_en while in DONE and not rd_empty pops the entry. rd_data is registered, rd_valid pulses one cycle later, and rp increments. rd_en while empty or not in DONE is ignored, and rd_valid stays 0. Back-to-back rd_en yields one word per cycle.
- rd_empty=1 outside DONE.
- start together with rd_en in DONE: start wins, the pop is dropped, and the buffer is reset.
- Arithmetic: no saturation. Ramp and the LFSR are two's-complement truncations.

Test Plan:
- Bench loops y_in back as sign-extended x_out delayed LAT=1 cycle. Impulse, amp=5, start -> busy for 17 cycles, then done=1. Read 16 words -> 8'h05 followed by fifteen 8'h00; rd_empty=1 after the 16th pop.
- Step, amp=-3, same loopback -> all 16 words 8'hFD. An extra rd_en when empty produces no rd_valid.
- Ramp -> words 0,1,...,15. LFSR -> first five x_out values 1,2,4,8,17.
- start pulsed during DRIVE is ignored, and the run still completes in 17 cycles. rst_n asserted mid-DRIVE -> x_out=0, busy=0 and rd_empty=1 immediately, without waiting for a clock edge.
- In DONE after 3 pops, start and rd_en in the same cycle -> no rd_valid, a new run begins, and the read pointer returns to 0.
